wash_cycle_controller: RTL and testbench

Sequences one wash cycle after a valid mode request from the coin/mode selector and drives the running flag back to it. It latches the 4-bit Mode word, runs FILL → WASH → RINSE → SPIN on a prescaled tick, and asserts isRunning for the whole cycle. Because the selector forces Mode to zero while isRunning is high, a running cycle cannot be re-triggered. The block sits between the mode selector and the actuator outputs (valve, motor, spin).

---
 rtl/wash_pkg.sv | 67 ++++++
 rtl/wash_cycle_controller_tick_prescaler.sv | 32 +++
 rtl/wash_cycle_controller.sv | 116 +++++++++++
 tb/tb_wash_cycle_controller.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared types and constants for the wash cycle controller.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package wash_pkg;

    // Encoding doubles as the Phase output value.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_SPIN  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    typedef enum logic {
        PROF_STD   = 1'b0,
        PROF_HEAVY = 1'b1
    } profile_t;

    localparam logic [3:0] MODE_STD   = 4'd2;
    localparam logic [3:0] MODE_HEAVY = 4'd10;

    // Phase durations in prescaler ticks.
    localparam logic [3:0] STD_FILL  = 4'd2;
    localparam logic [3:0] STD_WASH  = 4'd4;
    localparam logic [3:0] STD_RINSE = 4'd3;
    localparam logic [3:0] STD_SPIN  = 4'd2;
    localparam logic [3:0] HVY_FILL  = 4'd2;
    localparam logic [3:0] HVY_WASH  = 4'd8;
    localparam logic [3:0] HVY_RINSE = 4'd5;
    localparam logic [3:0] HVY_SPIN  = 4'd4;

    // Tick budget for a phase; zero for IDLE/DONE so the Remaining
    // counter naturally reads 0 there.
    function automatic logic [3:0] phase_ticks(input profile_t prof, input state_t st);
        logic [3:0] t;
        t = 4'd0;
        case (st)
            ST_FILL:  t = (prof == PROF_HEAVY) ? HVY_FILL  : STD_FILL;
            ST_WASH:  t = (prof == PROF_HEAVY) ? HVY_WASH  : STD_WASH;
            ST_RINSE: t = (prof == PROF_HEAVY) ? HVY_RINSE : STD_RINSE;
            ST_SPIN:  t = (prof == PROF_HEAVY) ? HVY_SPIN  : STD_SPIN;
            default:  t = 4'd0;
        endcase
        return t;
    endfunction

    function automatic state_t next_phase(input state_t st);
        state_t n;
        n = ST_IDLE;
        case (st)
            ST_FILL:  n = ST_WASH;
            ST_WASH:  n = ST_RINSE;
            ST_RINSE: n = ST_SPIN;
            ST_SPIN:  n = ST_DONE;
            default:  n = ST_IDLE;
        endcase
        return n;
    endfunction

    // FILL..SPIN: the span during which the machine is "running".
    function automatic logic is_active(input state_t st);
        return (st == ST_FILL) || (st == ST_WASH) || (st == ST_RINSE) || (st == ST_SPIN);
    endfunction

endpackage

// File: rtl/wash_cycle_controller_tick_prescaler.sv
// Divides clk into one-cycle phase ticks every TICK_DIV enabled cycles.
// Latency: tick is combinational from the count register (count == TICK_DIV-1 while enabled).
// Backpressure: en low freezes the count; clr forces it to 0 and wins over en.
// Ports: clk, rst (async high), en, clr in; tick out.
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = en && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/wash_cycle_controller.sv
// Sequences one FILL/WASH/RINSE/SPIN wash cycle per valid Mode request.
// Latency: outputs change one clk after the request/Stop edge; phases last duration*TICK_DIV cycles.
// Backpressure: DoorOpen freezes timing and drops actuators; Stop aborts to IDLE; Mode ignored unless IDLE.
// Ports: clk, rst (async high), Mode[3:0], Stop, DoorOpen in;
//        isRunning, Phase[2:0], Remaining[3:0], FillValve, Motor, SpinMotor, Done out.
module wash_cycle_controller #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Mode,
    input  logic       Stop,
    input  logic       DoorOpen,
    output logic       isRunning,
    output logic [2:0] Phase,
    output logic [3:0] Remaining,
    output logic       FillValve,
    output logic       Motor,
    output logic       SpinMotor,
    output logic       Done
);

    import wash_pkg::*;

    state_t     state_q, state_d;
    profile_t   prof_q, prof_d;
    logic [3:0] rem_q, rem_d;
    logic       paused_q, paused_d;
    logic       start;
    logic       tick;
    logic       presc_en;

    // Prescaler only advances in a running phase with the door shut.
    assign presc_en = is_active(state_q) && !DoorOpen;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (presc_en),
        .clr (start),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            prof_q   <= PROF_STD;
            rem_q    <= 4'd0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            prof_q   <= prof_d;
            rem_q    <= rem_d;
            paused_q <= paused_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prof_d  = prof_q;
        rem_d   = rem_q;
        start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((Mode == MODE_STD) || (Mode == MODE_HEAVY)) begin
                    start   = 1'b1;
                    prof_d  = (Mode == MODE_HEAVY) ? PROF_HEAVY : PROF_STD;
                    state_d = ST_FILL;
                    rem_d   = phase_ticks(prof_d, ST_FILL);
                end
            end

            ST_FILL, ST_WASH, ST_RINSE, ST_SPIN: begin
                // Stop beats DoorOpen beats tick.
                if (Stop) begin
                    state_d = ST_IDLE;
                    rem_d   = 4'd0;
                end else if (!DoorOpen && tick) begin
                    if (rem_q > 4'd1) begin
                        rem_d = rem_q - 4'd1;
                    end else begin
                        // Prescaler has just wrapped to 0, so the new phase
                        // starts with a full tick period.
                        state_d = next_phase(state_q);
                        rem_d   = phase_ticks(prof_q, state_d);
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                rem_d   = 4'd0;
            end

            default: begin
                state_d = ST_IDLE;
                rem_d   = 4'd0;
            end
        endcase

        // Registered door flag so actuator outputs stay pure register decodes.
        paused_d = DoorOpen && is_active(state_d);
    end

    assign isRunning = is_active(state_q);
    assign Phase     = state_q;
    assign Remaining = rem_q;
    assign FillValve = (state_q == ST_FILL) && !paused_q;
    assign Motor     = ((state_q == ST_WASH) || (state_q == ST_RINSE)) && !paused_q;
    assign SpinMotor = (state_q == ST_SPIN) && !paused_q;
    assign Done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Directed self-checking bench for wash_cycle_controller with TICK_DIV = 4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_wash_cycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Mode;
    logic       Stop;
    logic       DoorOpen;
    logic       isRunning;
    logic [2:0] Phase;
    logic [3:0] Remaining;
    logic       FillValve;
    logic       Motor;
    logic       SpinMotor;
    logic       Done;

    int checks   = 0;
    int failures = 0;

    // Results of the last run measurement.
    int         m_cycles;
    int         m_lens [0:7];
    logic [3:0] m_first[0:7];
    bit         m_order_ok;

    always #5 clk = ~clk;

    wash_cycle_controller #(
        .TICK_DIV(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Mode     (Mode),
        .Stop     (Stop),
        .DoorOpen (DoorOpen),
        .isRunning(isRunning),
        .Phase    (Phase),
        .Remaining(Remaining),
        .FillValve(FillValve),
        .Motor    (Motor),
        .SpinMotor(SpinMotor),
        .Done     (Done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks a running cycle from the current sample until isRunning drops,
    // recording per-phase lengths and the Remaining value on phase entry.
    task automatic measure();
        int guard;
        logic [2:0] prev;
        m_cycles   = 0;
        m_order_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_lens[i]  = 0;
            m_first[i] = 4'hF;
        end
        prev  = Phase;
        guard = 0;
        while (isRunning === 1'b1 && guard < 400) begin
            if (Phase !== prev && Phase !== prev + 3'd1) m_order_ok = 1'b0;
            if (m_lens[Phase] == 0) m_first[Phase] = Remaining;
            m_lens[Phase]++;
            m_cycles++;
            prev = Phase;
            step();
            guard++;
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; Mode = 4'd0; Stop = 1'b0; DoorOpen = 1'b0;
        #12;
        checks++;
        if ({isRunning, Phase, Remaining, FillValve, Motor, SpinMotor, Done} !== 12'd0) begin
            failures++;
            $display("FAIL reset_initial: outputs=%h required 0",
                     {isRunning, Phase, Remaining, FillValve, Motor, SpinMotor, Done});
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        Mode = 4'd2;
        step();
        Mode = 4'd0;
        step();
        step();
        checks++;
        if (FillValve !== 1'b1 || Phase !== 3'd1) begin
            failures++;
            $display("FAIL reset_prefill: FillValve=%b Phase=%0d required 1/1", FillValve, Phase);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({isRunning, Phase, Remaining, FillValve, Motor, SpinMotor, Done} !== 12'd0) begin
            failures++;
            $display("FAIL reset_async_midfill: outputs=%h required 0",
                     {isRunning, Phase, Remaining, FillValve, Motor, SpinMotor, Done});
        end
        #2 rst = 1'b0;
        bad = 0;
        repeat (20) begin
            step();
            if (Phase !== 3'd0 || isRunning !== 1'b0 || Remaining !== 4'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL idle_hold: %0d non-idle samples required 0", bad);
        end
    endtask

    task automatic test_standard();
        Mode = 4'd2;
        step();
        Mode = 4'd0;
        checks++;
        if (Phase !== 3'd1 || isRunning !== 1'b1 || FillValve !== 1'b1 || Remaining !== 4'd2) begin
            failures++;
            $display("FAIL std_start: Phase=%0d run=%b fill=%b rem=%0d required 1/1/1/2",
                     Phase, isRunning, FillValve, Remaining);
        end
        measure();
        checks++;
        if (m_cycles != 44) begin
            failures++;
            $display("FAIL std_run_len: got %0d required 44", m_cycles);
        end
        checks++;
        if (m_lens[1] != 8 || m_lens[2] != 16 || m_lens[3] != 12 || m_lens[4] != 8 || !m_order_ok) begin
            failures++;
            $display("FAIL std_phase_lens: %0d %0d %0d %0d order=%0d required 8 16 12 8 order=1",
                     m_lens[1], m_lens[2], m_lens[3], m_lens[4], m_order_ok);
        end
        checks++;
        if (m_first[2] !== 4'd4 || m_first[3] !== 4'd3 || m_first[4] !== 4'd2) begin
            failures++;
            $display("FAIL std_phase_loads: %0d %0d %0d required 4 3 2", m_first[2], m_first[3], m_first[4]);
        end
        checks++;
        if (Phase !== 3'd5 || Done !== 1'b1 || isRunning !== 1'b0 || Remaining !== 4'd0) begin
            failures++;
            $display("FAIL std_done: Phase=%0d Done=%b run=%b rem=%0d required 5/1/0/0",
                     Phase, Done, isRunning, Remaining);
        end
        step();
        checks++;
        if (Phase !== 3'd0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL std_back_idle: Phase=%0d Done=%b required 0/0", Phase, Done);
        end
    endtask

    task automatic test_heavy();
        Mode = 4'd10;
        step();
        Mode = 4'd0;
        checks++;
        if (Phase !== 3'd1 || Remaining !== 4'd2) begin
            failures++;
            $display("FAIL hvy_start: Phase=%0d rem=%0d required 1/2", Phase, Remaining);
        end
        measure();
        checks++;
        if (m_cycles != 76) begin
            failures++;
            $display("FAIL hvy_run_len: got %0d required 76", m_cycles);
        end
        checks++;
        if (m_lens[1] != 8 || m_lens[2] != 32 || m_lens[3] != 20 || m_lens[4] != 16 || !m_order_ok) begin
            failures++;
            $display("FAIL hvy_phase_lens: %0d %0d %0d %0d required 8 32 20 16",
                     m_lens[1], m_lens[2], m_lens[3], m_lens[4]);
        end
        checks++;
        if (m_first[2] !== 4'd8 || m_first[3] !== 4'd5 || m_first[4] !== 4'd4) begin
            failures++;
            $display("FAIL hvy_phase_loads: %0d %0d %0d required 8 5 4", m_first[2], m_first[3], m_first[4]);
        end
        step();
        checks++;
        if (Phase !== 3'd0) begin
            failures++;
            $display("FAIL hvy_back_idle: Phase=%0d required 0", Phase);
        end
    endtask

    task automatic test_invalid();
        Mode = 4'd3;
        step();
        checks++;
        if (Phase !== 3'd0 || isRunning !== 1'b0) begin
            failures++;
            $display("FAIL invalid_mode3: Phase=%0d required 0", Phase);
        end
        Mode = 4'd8;
        step();
        checks++;
        if (Phase !== 3'd0 || isRunning !== 1'b0) begin
            failures++;
            $display("FAIL invalid_mode8: Phase=%0d required 0", Phase);
        end
        Mode = 4'd2;
        step();
        // HEAVY request held for the whole run must not change the profile.
        Mode = 4'd10;
        measure();
        Mode = 4'd0;
        checks++;
        if (m_cycles != 44 || m_lens[2] != 16) begin
            failures++;
            $display("FAIL midrun_heavy_ignored: len=%0d wash=%0d required 44/16", m_cycles, m_lens[2]);
        end
        step();
        checks++;
        if (Phase !== 3'd0) begin
            failures++;
            $display("FAIL midrun_back_idle: Phase=%0d required 0", Phase);
        end
    endtask

    task automatic test_back_to_back();
        Mode = 4'd2;
        step();
        Mode = 4'd0;
        measure();
        // Request present during DONE: ignored there, taken at the IDLE edge.
        Mode = 4'd2;
        step();
        checks++;
        if (Phase !== 3'd0) begin
            failures++;
            $display("FAIL b2b_done_ignores_mode: Phase=%0d required 0", Phase);
        end
        step();
        Mode = 4'd0;
        checks++;
        if (Phase !== 3'd1 || Remaining !== 4'd2) begin
            failures++;
            $display("FAIL b2b_restart: Phase=%0d rem=%0d required 1/2", Phase, Remaining);
        end
        measure();
        checks++;
        if (m_cycles != 44) begin
            failures++;
            $display("FAIL b2b_run_len: got %0d required 44", m_cycles);
        end
        step();
    endtask

    task automatic test_pause();
        int n;
        int guard;
        int bad;
        Mode = 4'd2;
        step();
        Mode = 4'd0;
        n = 0;
        guard = 0;
        while (!(Phase === 3'd2 && Remaining === 4'd3) && guard < 200) begin
            step();
            n++;
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            failures++;
            $display("FAIL pause_reach_wash3: timeout Phase=%0d rem=%0d required 2/3", Phase, Remaining);
        end
        DoorOpen = 1'b1;
        bad = 0;
        repeat (10) begin
            step();
            n++;
            if (Motor !== 1'b0 || Remaining !== 4'd3 || isRunning !== 1'b1 || Phase !== 3'd2) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL pause_hold: %0d bad samples (motor/rem/run) required 0", bad);
        end
        DoorOpen = 1'b0;
        step();
        n++;
        checks++;
        if (Motor !== 1'b1 || Phase !== 3'd2) begin
            failures++;
            $display("FAIL pause_release: Motor=%b Phase=%0d required 1/2", Motor, Phase);
        end
        measure();
        checks++;
        if (n + m_cycles != 54) begin
            failures++;
            $display("FAIL pause_run_len: got %0d required 54", n + m_cycles);
        end
        step();
    endtask

    task automatic test_abort();
        int guard;
        Mode = 4'd2;
        step();
        Mode = 4'd0;
        guard = 0;
        while (Phase !== 3'd3 && guard < 200) begin
            step();
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            failures++;
            $display("FAIL abort_reach_rinse: timeout Phase=%0d required 3", Phase);
        end
        Stop = 1'b1;
        DoorOpen = 1'b1;
        step();
        Stop = 1'b0;
        DoorOpen = 1'b0;
        checks++;
        if (Phase !== 3'd0 || isRunning !== 1'b0 || Remaining !== 4'd0 || Done !== 1'b0 || Motor !== 1'b0) begin
            failures++;
            $display("FAIL abort_to_idle: Phase=%0d run=%b rem=%0d Done=%b Motor=%b required 0/0/0/0/0",
                     Phase, isRunning, Remaining, Done, Motor);
        end
        Mode = 4'd2;
        step();
        Mode = 4'd0;
        checks++;
        if (Phase !== 3'd1 || Remaining !== 4'd2 || FillValve !== 1'b1 || Done !== 1'b0) begin
            failures++;
            $display("FAIL abort_restart: Phase=%0d rem=%0d fill=%b Done=%b required 1/2/1/0",
                     Phase, Remaining, FillValve, Done);
        end
        measure();
        checks++;
        if (m_cycles != 44) begin
            failures++;
            $display("FAIL abort_fresh_len: got %0d required 44", m_cycles);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_standard();
        test_heavy();
        test_invalid();
        test_back_to_back();
        test_pause();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
